// File: rtl/alsu_pkg.sv
// Shared types and select-code table for the ALSU result queue.
package alsu_pkg;

  localparam logic [3:0] SEL_0000 = 4'b0000;
  localparam logic [3:0] SEL_0001 = 4'b0001;
  localparam logic [3:0] SEL_0010 = 4'b0010;
  localparam logic [3:0] SEL_0110 = 4'b0110;
  localparam logic [3:0] SEL_1010 = 4'b1010;
  localparam logic [3:0] SEL_0101 = 4'b0101;
  localparam logic [3:0] SEL_0111 = 4'b0111;
  localparam logic [3:0] SEL_1000 = 4'b1000;
  localparam logic [3:0] SEL_1110 = 4'b1110;
  localparam logic [3:0] SEL_1100 = 4'b1100;

  typedef struct packed {
    logic [3:0] sel;
    logic [3:0] result;
    logic       zero;
  } alsu_entry_t;

  function automatic bit is_legal_sel(logic [3:0] s);
    case (s)
      SEL_0000, SEL_0001, SEL_0010, SEL_0110, SEL_1010,
      SEL_0101, SEL_0111, SEL_1000, SEL_1110, SEL_1100: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alsu_result_queue_if.sv
// Producer/consumer handshake bundle of the ALSU result queue.
interface alsu_result_queue_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_result;
  logic [3:0] in_sel;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic [3:0] out_sel;
  logic       out_zero;

  modport slave (
    input  in_valid, in_result, in_sel, out_ready,
    output in_ready, out_valid, out_result, out_sel, out_zero
  );

  modport master (
    output in_valid, in_result, in_sel, out_ready,
    input  in_ready, out_valid, out_result, out_sel, out_zero
  );
endinterface

// File: rtl/alsu_sync_fifo.sv
// Show-ahead synchronous FIFO with exact occupancy count; DEPTH must be a power of two.
module alsu_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alsu_result_queue.sv
// Filters ALSU results by select code and queues legal ones for a valid/ready consumer.
// Optional ALSU_RESULT_QUEUE_STATS_EN adds saturating accepted/dropped counters.
module alsu_result_queue
  import alsu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  alsu_result_queue_if.slave  bus,
  output logic                illegal_pulse,
  output logic                err_sticky,
  input  logic                clr_err,
  output logic [AW:0]         count
`ifdef ALSU_RESULT_QUEUE_STATS_EN
  ,
  output logic [7:0]          stat_accepted,
  output logic [7:0]          stat_dropped
`endif
);

  alsu_entry_t wr_entry, head, hold_q;
  logic        full, empty, accept, push, drop, pop;
  logic        illegal_q, illegal_d, err_q, err_d;

  assign accept = bus.in_valid && !full;
  assign push   = accept && is_legal_sel(bus.in_sel);
  assign drop   = accept && !is_legal_sel(bus.in_sel);
  assign pop    = bus.out_ready && !empty;

  assign wr_entry = '{sel: bus.in_sel, result: bus.in_result, zero: (bus.in_result == 4'b0000)};

  alsu_sync_fifo #(.DEPTH(DEPTH), .WIDTH($bits(alsu_entry_t))) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  // While empty the outputs freeze on the last head that was presented.
  assign bus.in_ready   = !full;
  assign bus.out_valid  = !empty;
  assign bus.out_result = empty ? hold_q.result : head.result;
  assign bus.out_sel    = empty ? hold_q.sel    : head.sel;
  assign bus.out_zero   = empty ? hold_q.zero   : head.zero;

  // err rises together with the pulse; a clear coinciding with the pulse loses.
  assign illegal_d = drop;
  assign err_d     = drop | illegal_q | (err_q & ~clr_err);

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q    <= '0;
      illegal_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (!empty) hold_q <= head;
      illegal_q <= illegal_d;
      err_q     <= err_d;
    end
  end

  assign illegal_pulse = illegal_q;
  assign err_sticky    = err_q;

`ifdef ALSU_RESULT_QUEUE_STATS_EN
  logic [7:0] acc_q, drop_q;

  always_ff @(posedge clk) begin
    if (rst || clr_err) begin
      acc_q  <= '0;
      drop_q <= '0;
    end else begin
      if (push && acc_q != 8'hFF)  acc_q  <= acc_q + 1'b1;
      if (drop && drop_q != 8'hFF) drop_q <= drop_q + 1'b1;
    end
  end

  assign stat_accepted = acc_q;
  assign stat_dropped  = drop_q;
`endif

endmodule

// File: tb/tb_alsu_result_queue.sv
// Self-checking bench: scoreboard model of the queue plus a table of single-entry vectors.
module tb_alsu_result_queue;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr_err;
  logic       illegal_pulse;
  logic       err_sticky;
  logic [2:0] count;
`ifdef ALSU_RESULT_QUEUE_STATS_EN
  logic [7:0] stat_accepted;
  logic [7:0] stat_dropped;
`endif

  always #5 clk = ~clk;

  alsu_result_queue_if bus_if ();

  alsu_result_queue #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus_if.slave),
    .illegal_pulse (illegal_pulse),
    .err_sticky    (err_sticky),
    .clr_err       (clr_err),
    .count         (count)
`ifdef ALSU_RESULT_QUEUE_STATS_EN
    ,
    .stat_accepted (stat_accepted),
    .stat_dropped  (stat_dropped)
`endif
  );

  typedef struct {
    logic [3:0] sel;
    logic [3:0] res;
  } ent_t;

  typedef struct {
    logic [3:0] sel;
    logic [3:0] res;
    bit         exp_legal;
    bit         exp_zero;
  } vec_t;

  ent_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;
  bit   m_pulse, m_err;
  int   m_acc, m_drop;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal_tb(logic [3:0] s);
    case (s)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1010,
      4'b0101, 4'b0111, 4'b1000, 4'b1110, 4'b1100: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_state();
    chk("count", 32'(count), 32'(sb.size()));
    chk("in_ready", 32'(bus_if.in_ready), 32'(sb.size() < DEPTH));
    chk("out_valid", 32'(bus_if.out_valid), 32'(sb.size() > 0));
    chk("illegal_pulse", 32'(illegal_pulse), 32'(m_pulse));
    chk("err_sticky", 32'(err_sticky), 32'(m_err));
    if (sb.size() > 0) begin
      chk("out_result", 32'(bus_if.out_result), 32'(sb[0].res));
      chk("out_sel", 32'(bus_if.out_sel), 32'(sb[0].sel));
      chk("out_zero", 32'(bus_if.out_zero), 32'(sb[0].res == 4'h0));
    end
`ifdef ALSU_RESULT_QUEUE_STATS_EN
    chk("stat_accepted", 32'(stat_accepted), 32'(m_acc));
    chk("stat_dropped", 32'(stat_dropped), 32'(m_drop));
`endif
  endtask

  // Check current outputs, take one clock edge, advance the model.
  task automatic step();
    bit   acc, lg, pp, nerr;
    ent_t e;
    if (chk_en) check_state();
    acc   = bus_if.in_valid && (sb.size() < DEPTH);
    lg    = legal_tb(bus_if.in_sel);
    pp    = bus_if.out_ready && (sb.size() > 0);
    e.sel = bus_if.in_sel;
    e.res = bus_if.in_result;
    @(posedge clk);
    if (rst) begin
      sb.delete();
      m_pulse = 1'b0;
      m_err   = 1'b0;
      m_acc   = 0;
      m_drop  = 0;
    end else begin
      nerr = (acc && !lg) || m_pulse || (m_err && !clr_err);
      if (pp) void'(sb.pop_front());
      if (acc && lg) sb.push_back(e);
      if (clr_err) begin
        m_acc  = 0;
        m_drop = 0;
      end else begin
        if (acc && lg && m_acc < 255)   m_acc++;
        if (acc && !lg && m_drop < 255) m_drop++;
      end
      m_pulse = acc && !lg;
      m_err   = nerr;
    end
    @(negedge clk);
  endtask

  task automatic drive(bit v, logic [3:0] sel, logic [3:0] res, bit rdy, bit clr);
    bus_if.in_valid  = v;
    bus_if.in_sel    = sel;
    bus_if.in_result = res;
    bus_if.out_ready = rdy;
    clr_err          = clr;
  endtask

  vec_t tbl[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{sel: 4'b0000, res: 4'h0, exp_legal: 1'b1, exp_zero: 1'b1};
    tbl[1] = '{sel: 4'b1010, res: 4'hC, exp_legal: 1'b1, exp_zero: 1'b0};
    tbl[2] = '{sel: 4'b1111, res: 4'h3, exp_legal: 1'b0, exp_zero: 1'b0};
    tbl[3] = '{sel: 4'b0101, res: 4'h0, exp_legal: 1'b1, exp_zero: 1'b1};
    tbl[4] = '{sel: 4'b0100, res: 4'h0, exp_legal: 1'b0, exp_zero: 1'b1};
    tbl[5] = '{sel: 4'b1110, res: 4'hF, exp_legal: 1'b1, exp_zero: 1'b0};
    tbl[6] = '{sel: 4'b1001, res: 4'h8, exp_legal: 1'b0, exp_zero: 1'b0};
    tbl[7] = '{sel: 4'b1100, res: 4'h1, exp_legal: 1'b1, exp_zero: 1'b0};

    rst = 1'b1;
    drive(0, 4'h0, 4'h0, 0, 0);
    @(negedge clk);
    step();
    step();
    rst    = 1'b0;
    chk_en = 1'b1;

    // reset values
    chk("rst_out_result", 32'(bus_if.out_result), 0);
    chk("rst_out_sel", 32'(bus_if.out_sel), 0);
    chk("rst_out_zero", 32'(bus_if.out_zero), 0);
    chk("rst_in_ready", 32'(bus_if.in_ready), 1);
    step();

    // reset then single push
    drive(1, 4'b0010, 4'h5, 0, 0);
    step();
    drive(0, 4'h0, 4'h0, 0, 0);
    chk("push1_valid", 32'(bus_if.out_valid), 1);
    chk("push1_result", 32'(bus_if.out_result), 5);
    chk("push1_sel", 32'(bus_if.out_sel), 32'h2);
    chk("push1_zero", 32'(bus_if.out_zero), 0);
    chk("push1_count", 32'(count), 1);
    drive(0, 4'h0, 4'h0, 1, 0);
    step();

    // fill and backpressure
    for (int i = 1; i <= 5; i++) begin
      drive(1, 4'b0001, 4'(i), 0, 0);
      step();
    end
    drive(0, 4'h0, 4'h0, 0, 0);
    chk("fill_count", 32'(count), 4);
    chk("fill_in_ready", 32'(bus_if.in_ready), 0);
    drive(1, 4'b0011, 4'h9, 0, 0);
    step();
    chk("full_illegal_ignored", 32'(illegal_pulse), 0);
    for (int i = 1; i <= 4; i++) begin
      drive(0, 4'h0, 4'h0, 1, 0);
      chk("drain_order", 32'(bus_if.out_result), 32'(i));
      step();
    end
    chk("drain_empty", 32'(bus_if.out_valid), 0);
    chk("empty_hold_result", 32'(bus_if.out_result), 4);

    // illegal select, then clear
    drive(1, 4'b0011, 4'hA, 0, 0);
    step();
    drive(0, 4'h0, 4'h0, 0, 0);
    chk("ill_pulse", 32'(illegal_pulse), 1);
    chk("ill_sticky", 32'(err_sticky), 1);
    chk("ill_valid", 32'(bus_if.out_valid), 0);
    chk("ill_count", 32'(count), 0);
    step();
    chk("ill_pulse_gone", 32'(illegal_pulse), 0);
    drive(0, 4'h0, 4'h0, 0, 1);
    step();
    drive(0, 4'h0, 4'h0, 0, 0);
    chk("clr_sticky", 32'(err_sticky), 0);
    // clear coinciding with the pulse loses
    drive(1, 4'b1111, 4'h2, 0, 0);
    step();
    drive(0, 4'h0, 4'h0, 0, 1);
    step();
    drive(0, 4'h0, 4'h0, 0, 0);
    chk("set_wins", 32'(err_sticky), 1);
    drive(0, 4'h0, 4'h0, 0, 1);
    step();
    drive(0, 4'h0, 4'h0, 0, 0);
    step();

    // table-driven single entries
    for (int i = 0; i < 8; i++) begin
      drive(1, tbl[i].sel, tbl[i].res, 0, 0);
      step();
      drive(0, 4'h0, 4'h0, 1, 0);
      chk("tbl_valid", 32'(bus_if.out_valid), 32'(tbl[i].exp_legal));
      chk("tbl_pulse", 32'(illegal_pulse), 32'(!tbl[i].exp_legal));
      if (tbl[i].exp_legal) chk("tbl_zero", 32'(bus_if.out_zero), 32'(tbl[i].exp_zero));
      step();
      drive(0, 4'h0, 4'h0, 0, 1);
      step();
    end
    drive(0, 4'h0, 4'h0, 0, 0);
    step();

    // zero flag with concurrent push/pop
    drive(1, 4'b0110, 4'h3, 0, 0);
    step();
    drive(1, 4'b0111, 4'h7, 0, 0);
    step();
    drive(1, 4'b1000, 4'h0, 1, 0);
    step();
    drive(0, 4'h0, 4'h0, 1, 0);
    chk("conc_count", 32'(count), 2);
    step();
    chk("conc_zero", 32'(bus_if.out_zero), 1);
    chk("conc_result", 32'(bus_if.out_result), 0);
    step();
    drive(0, 4'h0, 4'h0, 0, 0);
    step();

    // pointer wrap, then reset mid-stream
    drive(1, 4'b0001, 4'hE, 0, 0);
    step();
    for (int i = 0; i < 10; i++) begin
      drive(1, 4'b0010, 4'(i + 3), 1, 0);
      step();
    end
    drive(1, 4'b0110, 4'h1, 0, 0);
    step();
    drive(1, 4'b0111, 4'h2, 0, 0);
    step();
    chk("wrap_count", 32'(count), 3);
    drive(0, 4'h0, 4'h0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(bus_if.out_valid), 0);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_ready", 32'(bus_if.in_ready), 1);
    drive(1, 4'b1100, 4'h9, 0, 0);
    step();
    drive(0, 4'h0, 4'h0, 1, 0);
    chk("post_rst_result", 32'(bus_if.out_result), 9);
    chk("post_rst_sel", 32'(bus_if.out_sel), 32'hC);
    step();
    chk("post_rst_empty", 32'(bus_if.out_valid), 0);
    step();

`ifdef ALSU_RESULT_QUEUE_STATS_EN
    drive(0, 4'h0, 4'h0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      drive(1, 4'b0001, 4'(i), 1, 0);
      step();
    end
    drive(1, 4'b1011, 4'h1, 1, 0);
    step();
    drive(1, 4'b1101, 4'h2, 1, 0);
    step();
    drive(0, 4'h0, 4'h0, 1, 0);
    step();
    chk("stat_acc_sat", 32'(stat_accepted), 32'hFF);
    chk("stat_drop", 32'(stat_dropped), 2);
    drive(0, 4'h0, 4'h0, 0, 1);
    step();
    drive(0, 4'h0, 4'h0, 0, 0);
    chk("stat_clr", 32'(stat_accepted), 0);
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alsu_result_queue.md
Name: alsu_result_queue

Overview:
- Downstream stage of the ALSU 4-bit result selector. Captures each selected 4-bit result together with its 4-bit operation select code.
- Rejects results whose select code the selector does not decode.
- Buffers legal results in a small FIFO and presents them to the consumer through a valid/ready handshake, with a zero flag per entry.
- Decouples the combinational ALSU datapath from slower consumers (display/register file).

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- AW, $clog2(DEPTH), pointer width; derived, not overridable.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  result/sel pair is valid this cycle.
- in_ready  out  1  queue can accept; equals !full.
- in_result  in  4  selected ALSU result.
- in_sel  in  4  operation select code that produced in_result.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head this cycle.
- out_result  out  4  head result.
- out_sel  out  4  head select code.
- out_zero  out  1  head result == 4'b0000.
- illegal_pulse  out  1  one-cycle pulse: an illegal-sel input was accepted and dropped.
- err_sticky  out  1  set by any illegal_pulse; held until clr_err.
- clr_err  in  1  clears err_sticky.
- count  out  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Clock/reset: one clock, clk; reset is rst, synchronous, active-high.
- Reset values: all pointers and count = 0, out_valid = 0, out_result = 0, out_sel = 0, out_zero = 0, illegal_pulse = 0, err_sticky = 0; in_ready = 1 in the first cycle after reset.
- Reset mid-operation: all stored entries are discarded, no output is produced for them.
- Legal sel set: {0000, 0001, 0010, 0110, 1010, 0101, 0111, 1000, 1110, 1100}. All other codes are illegal.
- Accept: in_valid && in_ready.
  - Legal sel: entry {sel, result, zero} written at the tail; tail pointer increments.
  - Illegal sel: handshake completes, nothing stored, illegal_pulse = 1 in the next cycle.
- Pop: out_valid && out_ready. Head pointer increments.
- Pointers wrap modulo DEPTH.
- Output is show-ahead and registered from FIFO storage.
  - Push into an empty queue at edge N gives out_valid = 1 after edge N; latency is one cycle.
  - There is no same-cycle input-to-output bypass.
- Full (count == DEPTH):
  - in_ready = 0; in_valid is ignored.
  - Illegal-sel inputs are not acknowledged while full.
- Simultaneous push and pop when not full and not empty: count is unchanged and both pointers advance.
- Simultaneous push and pop when empty: not possible, since out_valid = 0.
- Empty: out_valid = 0. out_result, out_sel and out_zero hold their last values; they carry no meaning.
- Consumer rule: out_result, out_sel and out_zero are stable while out_valid && !out_ready.
- err_sticky:
  - Set on the cycle illegal_pulse is 1.
  - clr_err clears it.
  - If clr_err and a new illegal_pulse occur in the same cycle, set wins.
- count is exact at all times, with no overflow or underflow. A pop on empty or a push on full has no effect.

Optional Feature:
- Macro: ALSU_RESULT_QUEUE_STATS_EN.
- Defined: adds outputs stat_accepted[7:0] and stat_dropped[7:0].
  - stat_accepted increments on each legal push.
  - stat_dropped increments on each illegal-sel accept.
  - Both saturate at 8'hFF, reset to 0 on rst, and are cleared with clr_err.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package alsu_pkg:
  - localparams for the ten legal select codes.
  - Function is_legal_sel(logic [3:0]) returning bit.
  - Packed typedef alsu_entry_t {sel[3:0], result[3:0], zero}.
- Sub-module alsu_sync_fifo (parameter DEPTH, WIDTH = 9):
  - Storage, pointers, count, full/empty.
  - The top holds the legality filter, flag generation, error logic and optional stats.

Test Plan:
- Reset then single push: rst held 2 cycles; push sel=0010, result=4'h5. Expected: out_valid = 1 one cycle later with out_result=5, out_sel=0010, out_zero=0; count=1.
- Fill and backpressure: out_ready=0; push 5 legal entries (results 1,2,3,4,5) with DEPTH=4. Expected: in_ready drops after the 4th push, count=4, 5th push not accepted. Draining then yields 1,2,3,4 in order.
- Illegal sel: push sel=0011, result=4'hA into an empty queue. Expected: illegal_pulse = 1 for one cycle, err_sticky = 1, out_valid stays 0, count=0. Assert clr_err: err_sticky = 0.
- Zero flag and concurrency: queue holds 2 entries; push result=0 with sel=1000 while popping, in the same cycle. Expected: count stays 2, and the new entry later appears with out_zero=1.
- Wrap and reset mid-stream: perform 10 push/pop pairs to wrap the pointers, then assert rst with 3 entries queued. Expected: next cycle out_valid=0, count=0, in_ready=1, and no stale data after subsequent pushes.
- Stats (macro defined): 300 legal pushes and 2 illegal ones. Expected: stat_accepted=8'hFF (saturated), stat_dropped=2.
